// File: rtl/lobinho_pkg.sv
// Shared definitions for the werewolf (lobinho) game-state datapath:
// role codes, game phases and default sizing.
package lobinho_pkg;

    localparam int N_JOG_PADRAO          = 5;
    localparam int W_IDX_PADRAO          = 3;
    localparam int MORTES_VITORIA_PADRAO = 3;

    localparam logic [1:0] CLASSE_ALDEAO = 2'd0;
    localparam logic [1:0] CLASSE_LOBO   = 2'd1;
    localparam logic [1:0] CLASSE_MEDICO = 2'd2;

    typedef enum logic [1:0] {
        FASE_OCIOSO    = 2'd0,
        FASE_NOITE     = 2'd1,
        FASE_RESOLVIDA = 2'd2,
        FASE_VOTACAO   = 2'd3
    } fase_t;

endpackage

// File: rtl/atribui_classes.sv
// Maps the 8-bit seed to wolf and doctor indices. Purely combinational; the
// parent registers the result when the seed strobe arrives.
module atribui_classes
    import lobinho_pkg::*;
#(
    parameter int N_JOG = N_JOG_PADRAO,
    parameter int W_IDX = W_IDX_PADRAO
) (
    input  logic [7:0]       seed,
    output logic [W_IDX-1:0] lobo_idx,
    output logic [W_IDX-1:0] medico_idx
);

    localparam logic [7:0]       N8      = 8'(N_JOG);
    localparam logic [W_IDX-1:0] ULTIMO  = W_IDX'(N_JOG - 1);

    always_comb begin
        lobo_idx   = W_IDX'(seed % N8);
        medico_idx = W_IDX'((seed / N8) % N8);
        // The doctor may never share the wolf's seat; bump to the next player.
        if (medico_idx == lobo_idx) begin
            medico_idx = (lobo_idx == ULTIMO) ? '0 : lobo_idx + 1'b1;
        end
    end

endmodule

// File: rtl/estado_jogadores.sv
// Game-state datapath for the werewolf game: roles, alive mask, night targets,
// the day vote and the status flags returned to the control unit.
module estado_jogadores
    import lobinho_pkg::*;
#(
    parameter int N_JOG          = N_JOG_PADRAO,
    parameter int W_IDX          = W_IDX_PADRAO,
    parameter int MORTES_VITORIA = MORTES_VITORIA_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rst_global,
    input  logic [7:0]       seed,
    input  logic             e_seed_reg,
    input  logic [W_IDX-1:0] jogador_atual,
    input  logic             processar_acao,
    input  logic             passa,
    input  logic [W_IDX-1:0] alvo,
    input  logic             avaliar_eliminacao,
    input  logic             voto,
    input  logic             morra,
    output logic             jogador_vivo,
    output logic [1:0]       classe_atual,
    output logic [N_JOG-1:0] vivos,
    output logic             morte_valida,
    output logic [W_IDX-1:0] morte_idx,
    output logic             votou,
    output logic             acertou,
    output logic             sinal_lobo_ganhou
);

    localparam int                  W_MORTES    = $clog2(N_JOG + 1);
    localparam int                  N_SLOTS     = 2 ** W_IDX;
    localparam logic [W_IDX:0]      LIMITE      = (W_IDX + 1)'(N_JOG);
    localparam logic [W_MORTES-1:0] MORTES_MAX  = W_MORTES'(N_JOG);
    localparam logic [W_MORTES-1:0] MORTES_LOBO = W_MORTES'(MORTES_VITORIA);

    fase_t               fase_reg, fase_next;
    logic [N_JOG-1:0]    vivos_reg, vivos_next;
    logic [W_MORTES-1:0] mortes_reg, mortes_next;
    logic [W_IDX-1:0]    lobo_idx_reg, lobo_idx_next;
    logic [W_IDX-1:0]    medico_idx_reg, medico_idx_next;
    logic [W_IDX-1:0]    alvo_lobo_reg, alvo_lobo_next;
    logic [W_IDX-1:0]    alvo_medico_reg, alvo_medico_next;
    logic [W_IDX-1:0]    voto_idx_reg, voto_idx_next;
    logic [W_IDX-1:0]    morte_idx_reg, morte_idx_next;
    logic                alvo_lobo_valid_reg, alvo_lobo_valid_next;
    logic                votou_reg, votou_next;
    logic                morte_valida_reg, morte_valida_next;
    logic                lobo_ganhou_reg, lobo_ganhou_next;

    logic [W_IDX-1:0]    seed_lobo, seed_medico;
    logic [N_SLOTS-1:0]  vivo_pad;
    logic [1:0]          classe_de [N_SLOTS];
    logic                alvo_ok, e_lobo, e_medico, acao, mata_noite, pode_votar;
    logic                mata_dia, conta_morte;

    atribui_classes #(
        .N_JOG(N_JOG),
        .W_IDX(W_IDX)
    ) u_atribui_classes (
        .seed      (seed),
        .lobo_idx  (seed_lobo),
        .medico_idx(seed_medico)
    );

    // Pad per-player views to the full index range so out-of-range indices read as 0.
    genvar gi;
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_jog
        if (gi < N_JOG) begin : g_valido
            assign vivo_pad[gi]  = vivos_reg[gi];
            assign classe_de[gi] = (W_IDX'(gi) == lobo_idx_reg)   ? CLASSE_LOBO   :
                                   (W_IDX'(gi) == medico_idx_reg) ? CLASSE_MEDICO :
                                                                    CLASSE_ALDEAO;
        end else begin : g_fora
            assign vivo_pad[gi]  = 1'b0;
            assign classe_de[gi] = CLASSE_ALDEAO;
        end
    end

    assign jogador_vivo      = vivo_pad[jogador_atual];
    assign classe_atual      = classe_de[jogador_atual];
    assign vivos             = vivos_reg;
    assign morte_valida      = morte_valida_reg;
    assign morte_idx         = morte_idx_reg;
    assign votou             = votou_reg;
    assign acertou           = votou_reg && (voto_idx_reg == lobo_idx_reg);
    assign sinal_lobo_ganhou = lobo_ganhou_reg;

    always_comb begin
        alvo_ok    = ({1'b0, alvo} < LIMITE);
        acao       = processar_acao && passa &&
                     (fase_reg == FASE_OCIOSO || fase_reg == FASE_NOITE);
        e_lobo     = (jogador_atual == lobo_idx_reg) && vivo_pad[lobo_idx_reg];
        e_medico   = (jogador_atual == medico_idx_reg) && vivo_pad[medico_idx_reg];
        // A dead doctor's last target no longer protects anyone.
        mata_noite = alvo_lobo_valid_reg && vivo_pad[alvo_lobo_reg] &&
                     !(vivo_pad[medico_idx_reg] && (alvo_lobo_reg == alvo_medico_reg));
        pode_votar = voto && passa && alvo_ok && vivo_pad[alvo];
        mata_dia   = (fase_reg == FASE_VOTACAO) && morra && !avaliar_eliminacao;
    end

    always_comb begin
        fase_next = fase_reg;
        case (fase_reg)
            FASE_OCIOSO:    if (processar_acao)     fase_next = FASE_NOITE;
            FASE_NOITE:     if (avaliar_eliminacao) fase_next = FASE_RESOLVIDA;
            FASE_RESOLVIDA: if (voto)               fase_next = FASE_VOTACAO;
            FASE_VOTACAO:   if (mata_dia || (!voto && acertou)) fase_next = FASE_OCIOSO;
            default:        fase_next = FASE_OCIOSO;
        endcase
    end

    always_comb begin
        vivos_next           = vivos_reg;
        mortes_next          = mortes_reg;
        lobo_idx_next        = lobo_idx_reg;
        medico_idx_next      = medico_idx_reg;
        alvo_lobo_next       = alvo_lobo_reg;
        alvo_medico_next     = alvo_medico_reg;
        alvo_lobo_valid_next = alvo_lobo_valid_reg;
        voto_idx_next        = voto_idx_reg;
        votou_next           = votou_reg;
        morte_valida_next    = morte_valida_reg;
        morte_idx_next       = morte_idx_reg;
        lobo_ganhou_next     = (mortes_reg >= MORTES_LOBO);
        conta_morte          = 1'b0;

        if (e_seed_reg) begin
            lobo_idx_next   = seed_lobo;
            medico_idx_next = seed_medico;
        end

        if (fase_reg == FASE_OCIOSO && processar_acao) begin
            alvo_lobo_valid_next = 1'b0;
        end
        if (acao && alvo_ok) begin
            if (e_lobo) begin
                alvo_lobo_next       = alvo;
                alvo_lobo_valid_next = 1'b1;
            end
            if (e_medico) begin
                alvo_medico_next = alvo;
            end
        end

        if (fase_reg == FASE_NOITE && avaliar_eliminacao) begin
            if (mata_noite) begin
                vivos_next[alvo_lobo_reg] = 1'b0;
                conta_morte               = 1'b1;
                morte_valida_next         = 1'b1;
                morte_idx_next            = alvo_lobo_reg;
            end else begin
                morte_valida_next = 1'b0;
            end
        end

        if (fase_reg == FASE_RESOLVIDA && voto) begin
            votou_next = 1'b0;
        end
        if (fase_reg == FASE_VOTACAO && pode_votar) begin
            voto_idx_next = alvo;
            votou_next    = 1'b1;
        end
        if (mata_dia) begin
            vivos_next[voto_idx_reg] = 1'b0;
            conta_morte              = vivo_pad[voto_idx_reg];
            votou_next               = 1'b0;
        end

        if (conta_morte && (mortes_reg < MORTES_MAX)) begin
            mortes_next = mortes_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || rst_global) begin
            fase_reg            <= FASE_OCIOSO;
            vivos_reg           <= '1;
            mortes_reg          <= '0;
            lobo_idx_reg        <= '0;
            medico_idx_reg      <= W_IDX'(1);
            alvo_lobo_reg       <= '0;
            alvo_medico_reg     <= '0;
            alvo_lobo_valid_reg <= 1'b0;
            voto_idx_reg        <= '0;
            votou_reg           <= 1'b0;
            morte_valida_reg    <= 1'b0;
            morte_idx_reg       <= '0;
            lobo_ganhou_reg     <= 1'b0;
        end else begin
            fase_reg            <= fase_next;
            vivos_reg           <= vivos_next;
            mortes_reg          <= mortes_next;
            lobo_idx_reg        <= lobo_idx_next;
            medico_idx_reg      <= medico_idx_next;
            alvo_lobo_reg       <= alvo_lobo_next;
            alvo_medico_reg     <= alvo_medico_next;
            alvo_lobo_valid_reg <= alvo_lobo_valid_next;
            voto_idx_reg        <= voto_idx_next;
            votou_reg           <= votou_next;
            morte_valida_reg    <= morte_valida_next;
            morte_idx_reg       <= morte_idx_next;
            lobo_ganhou_reg     <= lobo_ganhou_next;
        end
    end

endmodule

// File: tb/tb_estado_jogadores.sv
// Scenario bench for estado_jogadores: expected status words are queued as each
// stimulus is driven and compared against the captured DUT status afterwards.
module tb_estado_jogadores;

    logic       clock = 1'b0;
    logic       reset, rst_global, e_seed_reg, processar_acao, passa;
    logic       avaliar_eliminacao, voto, morra;
    logic [7:0] seed;
    logic [2:0] jogador_atual, alvo;
    logic       jogador_vivo, morte_valida, votou, acertou, sinal_lobo_ganhou;
    logic [1:0] classe_atual;
    logic [4:0] vivos;
    logic [2:0] morte_idx;

    // {jogador_vivo, classe_atual, vivos, morte_valida, morte_idx, votou, acertou, sinal}
    logic [14:0] status;
    assign status = {jogador_vivo, classe_atual, vivos, morte_valida, morte_idx,
                     votou, acertou, sinal_lobo_ganhou};

    typedef struct {
        string       nome;
        logic [14:0] st;
    } esperado_t;

    esperado_t   sb[$];
    logic [14:0] obs[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clock = ~clock;

    estado_jogadores dut (
        .clock             (clock),
        .reset             (reset),
        .rst_global        (rst_global),
        .seed              (seed),
        .e_seed_reg        (e_seed_reg),
        .jogador_atual     (jogador_atual),
        .processar_acao    (processar_acao),
        .passa             (passa),
        .alvo              (alvo),
        .avaliar_eliminacao(avaliar_eliminacao),
        .voto              (voto),
        .morra             (morra),
        .jogador_vivo      (jogador_vivo),
        .classe_atual      (classe_atual),
        .vivos             (vivos),
        .morte_valida      (morte_valida),
        .morte_idx         (morte_idx),
        .votou             (votou),
        .acertou           (acertou),
        .sinal_lobo_ganhou (sinal_lobo_ganhou)
    );

    function automatic logic [14:0] st(int jv, int cl, int vv, int mv, int mi,
                                       int vt, int ac, int sg);
        return {1'(jv), 2'(cl), 5'(vv), 1'(mv), 3'(mi), 1'(vt), 1'(ac), 1'(sg)};
    endfunction

    // Queue the expectation, let one edge pass, capture the DUT, drop the pulses.
    task automatic ciclo(input string nome, input logic [14:0] esp);
        sb.push_back('{nome, esp});
        @(posedge clock);
        #1;
        obs.push_back(status);
        reset              = 1'b0;
        rst_global         = 1'b0;
        e_seed_reg         = 1'b0;
        processar_acao     = 1'b0;
        passa              = 1'b0;
        avaliar_eliminacao = 1'b0;
        morra              = 1'b0;
    endtask

    // Combinational look-up only: no clock edge.
    task automatic olha(input string nome, input logic [14:0] esp);
        sb.push_back('{nome, esp});
        #1;
        obs.push_back(status);
    endtask

    task automatic acao(input int jog, input int tgt, input logic [14:0] esp);
        jogador_atual  = 3'(jog);
        alvo           = 3'(tgt);
        processar_acao = 1'b1;
        passa          = 1'b1;
        ciclo($sformatf("acao_j%0d_alvo%0d", jog, tgt), esp);
    endtask

    task automatic test_reset;
        esperado_t e;
        logic [14:0] o;
        reset = 1'b1; seed = 8'd7; e_seed_reg = 1'b1; jogador_atual = 3'd0;
        ciclo("reset_prioridade", st(1, 1, 5'h1f, 0, 0, 0, 0, 0));
        jogador_atual = 3'd1;
        olha("reset_medico", st(1, 2, 5'h1f, 0, 0, 0, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); total++;
            if (o !== e.st) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.nome, o, e.st);
            end else $display("txn %s status=%b", e.nome, o);
        end
    endtask

    task automatic test_roles;
        esperado_t e;
        logic [14:0] o;
        seed = 8'd7; e_seed_reg = 1'b1; jogador_atual = 3'd0;
        ciclo("seed7", st(1, 0, 5'h1f, 0, 0, 0, 0, 0));
        for (int j = 0; j < 8; j++) begin
            jogador_atual = 3'(j);
            olha($sformatf("seed7_j%0d", j),
                 st((j < 5) ? 1 : 0, (j == 2) ? 1 : (j == 1) ? 2 : 0, 5'h1f, 0, 0, 0, 0, 0));
        end
        seed = 8'd6; e_seed_reg = 1'b1; jogador_atual = 3'd1;
        ciclo("seed6_lobo", st(1, 1, 5'h1f, 0, 0, 0, 0, 0));
        jogador_atual = 3'd2;
        olha("seed6_medico_colisao", st(1, 2, 5'h1f, 0, 0, 0, 0, 0));
        seed = 8'd24; e_seed_reg = 1'b1; jogador_atual = 3'd4;
        ciclo("seed24_lobo", st(1, 1, 5'h1f, 0, 0, 0, 0, 0));
        jogador_atual = 3'd0;
        olha("seed24_medico_volta", st(1, 2, 5'h1f, 0, 0, 0, 0, 0));
        seed = 8'd7; e_seed_reg = 1'b1; jogador_atual = 3'd2;
        ciclo("seed7_again", st(1, 1, 5'h1f, 0, 0, 0, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); total++;
            if (o !== e.st) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.nome, o, e.st);
            end else $display("txn %s status=%b", e.nome, o);
        end
    endtask

    task automatic test_night_kill;
        esperado_t e;
        logic [14:0] o;
        jogador_atual = 3'd0; processar_acao = 1'b1;
        ciclo("entra_noite", st(1, 0, 5'h1f, 0, 0, 0, 0, 0));
        acao(1, 0, st(1, 2, 5'h1f, 0, 0, 0, 0, 0));
        acao(2, 6, st(1, 1, 5'h1f, 0, 0, 0, 0, 0));
        acao(2, 4, st(1, 1, 5'h1f, 0, 0, 0, 0, 0));
        acao(3, 2, st(1, 0, 5'h1f, 0, 0, 0, 0, 0));
        avaliar_eliminacao = 1'b1;
        ciclo("mata_noite", st(1, 0, 5'b01111, 1, 4, 0, 0, 0));
        jogador_atual = 3'd4;
        olha("vitima_morta", st(0, 0, 5'b01111, 1, 4, 0, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); total++;
            if (o !== e.st) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.nome, o, e.st);
            end else $display("txn %s status=%b", e.nome, o);
        end
    endtask

    task automatic test_vote;
        esperado_t e;
        logic [14:0] o;
        voto = 1'b1;
        ciclo("entra_voto", st(0, 0, 5'b01111, 1, 4, 0, 0, 0));
        alvo = 3'd4; passa = 1'b1;
        ciclo("voto_morto", st(0, 0, 5'b01111, 1, 4, 0, 0, 0));
        alvo = 3'd2; passa = 1'b1;
        ciclo("voto_lobo", st(0, 0, 5'b01111, 1, 4, 1, 1, 0));
        alvo = 3'd3; passa = 1'b1;
        ciclo("voto_troca", st(0, 0, 5'b01111, 1, 4, 1, 0, 0));
        jogador_atual = 3'd3; morra = 1'b1;
        ciclo("morra_j3", st(0, 0, 5'b00111, 1, 4, 0, 0, 0));
        voto = 1'b0;
        ciclo("pos_morra", st(0, 0, 5'b00111, 1, 4, 0, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); total++;
            if (o !== e.st) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.nome, o, e.st);
            end else $display("txn %s status=%b", e.nome, o);
        end
    endtask

    task automatic test_protection;
        esperado_t e;
        logic [14:0] o;
        jogador_atual = 3'd0; processar_acao = 1'b1;
        ciclo("noite2", st(1, 0, 5'b00111, 1, 4, 0, 0, 0));
        acao(1, 2, st(1, 2, 5'b00111, 1, 4, 0, 0, 0));
        acao(2, 2, st(1, 1, 5'b00111, 1, 4, 0, 0, 0));
        voto = 1'b1; passa = 1'b1; alvo = 3'd0;
        ciclo("voto_fora_de_fase", st(1, 1, 5'b00111, 1, 4, 0, 0, 0));
        voto = 1'b0; avaliar_eliminacao = 1'b1;
        ciclo("protegido", st(1, 1, 5'b00111, 0, 4, 0, 0, 0));
        voto = 1'b1;
        ciclo("entra_voto2", st(1, 1, 5'b00111, 0, 4, 0, 0, 0));
        alvo = 3'd0; passa = 1'b1;
        ciclo("voto_j0", st(1, 1, 5'b00111, 0, 4, 1, 0, 0));
        jogador_atual = 3'd0; morra = 1'b1;
        ciclo("terceira_morte", st(0, 0, 5'b00110, 0, 4, 0, 0, 0));
        voto = 1'b0;
        ciclo("lobo_ganhou", st(0, 0, 5'b00110, 0, 4, 0, 0, 1));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); total++;
            if (o !== e.st) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.nome, o, e.st);
            end else $display("txn %s status=%b", e.nome, o);
        end
    endtask

    task automatic test_back_to_back;
        esperado_t e;
        logic [14:0] o;
        jogador_atual = 3'd1; processar_acao = 1'b1;
        ciclo("noite3", st(1, 2, 5'b00110, 0, 4, 0, 0, 1));
        acao(1, 1, st(1, 2, 5'b00110, 0, 4, 0, 0, 1));
        acao(2, 7, st(1, 1, 5'b00110, 0, 4, 0, 0, 1));
        avaliar_eliminacao = 1'b1;
        ciclo("alvo_invalido_sem_morte", st(1, 1, 5'b00110, 0, 4, 0, 0, 1));
        voto = 1'b1;
        ciclo("entra_voto3", st(1, 1, 5'b00110, 0, 4, 0, 0, 1));
        alvo = 3'd2; passa = 1'b1;
        ciclo("voto_acerto", st(1, 1, 5'b00110, 0, 4, 1, 1, 1));
        voto = 1'b0;
        ciclo("fim_de_jogo", st(1, 1, 5'b00110, 0, 4, 1, 1, 1));
        morra = 1'b1;
        ciclo("morra_ignorado", st(1, 1, 5'b00110, 0, 4, 1, 1, 1));
        jogador_atual = 3'd0; rst_global = 1'b1;
        ciclo("rst_global", st(1, 1, 5'h1f, 0, 0, 0, 0, 0));
        ciclo("pos_rst_global", st(1, 1, 5'h1f, 0, 0, 0, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); total++;
            if (o !== e.st) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.nome, o, e.st);
            end else $display("txn %s status=%b", e.nome, o);
        end
    endtask

    initial begin
        reset = 1'b0; rst_global = 1'b0; e_seed_reg = 1'b0; processar_acao = 1'b0;
        passa = 1'b0; avaliar_eliminacao = 1'b0; voto = 1'b0; morra = 1'b0;
        seed = 8'd0; jogador_atual = 3'd0; alvo = 3'd0;
        @(negedge clock);
        test_reset();
        test_roles();
        test_night_kill();
        test_vote();
        test_protection();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
